step_cmd_ctrl: RTL

Command sequencer that sits between the SPI byte receiver and the stepper phase driver. It parses 5-byte command frames from the SPI byte stream and holds the step period, direction, enable and move-length configuration. It runs a step/dir pulse generator that schedules moves. Each cycle it presents a status byte on the SPI transmit register so the host reads the status back on its next transfer.

---
 rtl/step_cmd_ctrl.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/step_cmd_ctrl.sv
// SPI command sequencer: parses 5-byte frames (opcode + 32-bit payload, MSB first),
// holds step configuration, drives a step/dir pulse generator and returns a status byte.
module step_cmd_ctrl #(
  parameter logic [31:0] PERIOD_RST = 32'd16000,
  parameter logic [31:0] PERIOD_MIN = 32'd2
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       byte_received,
  input  logic [7:0] byte_data_received,
  output logic [7:0] spi_send_data,
  output logic       step,
  output logic       dir,
  output logic       enable,
  output logic       busy,
  output logic       fault
);

  // state   | meaning
  // P_OP    | waiting for the opcode byte of a frame
  // P_ARG   | collecting the four payload bytes
  // P_EXEC  | single cycle in which the frame is executed
  // M_IDLE  | no move in progress
  // M_SETUP | dir settles, counters and period are loaded
  // M_RUN   | generating step pulses

  typedef enum logic [1:0] {P_OP, P_ARG, P_EXEC} p_state_t;
  typedef enum logic [1:0] {M_IDLE, M_SETUP, M_RUN} m_state_t;

  localparam logic [7:0] OP_SET_PERIOD = 8'h01;
  localparam logic [7:0] OP_MOVE       = 8'h02;
  localparam logic [7:0] OP_STOP       = 8'h03;
  localparam logic [7:0] OP_ENABLE     = 8'h04;
  localparam logic [7:0] OP_CLEAR      = 8'h05;

  p_state_t    p_state, p_next;
  m_state_t    m_state, m_next;

  logic        byte_received_q;
  logic        rx_stb;
  logic [7:0]  opcode;
  logic [31:0] payload;
  logic [1:0]  idx;

  logic        exec_set_period;
  logic        exec_move;
  logic        exec_stop;
  logic        exec_enable;
  logic        exec_clear;
  logic        exec_bad;

  logic [31:0] period;
  logic [30:0] move_n;
  logic [30:0] move_n_q;
  logic        move_dir;
  logic        set_period_ok;
  logic        move_ok;
  logic        move_start;
  logic        abort;
  logic        fault_set;

  logic [31:0] period_eng;
  logic [31:0] pc;
  logic [30:0] remaining;
  logic        pc_wrap;

  // ---------------------------------------------------------------- byte strobe
  always_ff @(posedge CLK) begin
    if (reset) byte_received_q <= 1'b0;
    else       byte_received_q <= byte_received;
  end

  assign rx_stb = byte_received & ~byte_received_q;

  // ---------------------------------------------------------------- parser FSM
  always_ff @(posedge CLK) begin
    if (reset) p_state <= P_OP;
    else       p_state <= p_next;
  end

  always_comb begin
    p_next = p_state;
    case (p_state)
      P_OP:    if (rx_stb) p_next = P_ARG;
      P_ARG:   if (rx_stb && idx == 2'd3) p_next = P_EXEC;
      P_EXEC:  p_next = P_OP;
      default: p_next = P_OP;
    endcase
  end

  always_comb begin
    exec_set_period = 1'b0;
    exec_move       = 1'b0;
    exec_stop       = 1'b0;
    exec_enable     = 1'b0;
    exec_clear      = 1'b0;
    exec_bad        = 1'b0;
    if (p_state == P_EXEC) begin
      case (opcode)
        OP_SET_PERIOD: exec_set_period = 1'b1;
        OP_MOVE:       exec_move       = 1'b1;
        OP_STOP:       exec_stop       = 1'b1;
        OP_ENABLE:     exec_enable     = 1'b1;
        OP_CLEAR:      exec_clear      = 1'b1;
        default:       exec_bad        = 1'b1;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      opcode  <= 8'h00;
      payload <= 32'h0000_0000;
      idx     <= 2'd0;
    end else if (rx_stb) begin
      if (p_state == P_OP) begin
        opcode <= byte_data_received;
        idx    <= 2'd0;
      end else if (p_state == P_ARG) begin
        payload <= {payload[23:0], byte_data_received};
        idx     <= idx + 2'd1;
      end
    end
  end

  // ---------------------------------------------------------------- command decode
  assign move_n   = payload[30:0];
  assign move_dir = payload[31];

  assign set_period_ok = exec_set_period & (payload >= PERIOD_MIN) & ~busy;
  assign move_ok       = exec_move & ~busy & enable;
  assign move_start    = move_ok & (move_n != 31'd0);
  // Aborting an idle engine is harmless, so no busy qualification is needed.
  assign abort         = exec_stop | (exec_enable & ~payload[0]);
  assign fault_set     = (exec_set_period & ~set_period_ok)
                       | (exec_move & ~move_ok)
                       | exec_bad;

  always_ff @(posedge CLK) begin
    if (reset) begin
      period   <= PERIOD_RST;
      enable   <= 1'b0;
      fault    <= 1'b0;
      dir      <= 1'b1;
      move_n_q <= 31'd0;
    end else begin
      if (set_period_ok) period <= payload;
      if (exec_enable)   enable <= payload[0];
      if (fault_set)       fault <= 1'b1;
      else if (exec_clear) fault <= 1'b0;
      if (move_start) begin
        dir      <= move_dir;
        move_n_q <= move_n;
      end
    end
  end

  // ---------------------------------------------------------------- move engine FSM
  always_ff @(posedge CLK) begin
    if (reset) m_state <= M_IDLE;
    else       m_state <= m_next;
  end

  assign pc_wrap = (pc == period_eng - 32'd1);

  always_comb begin
    m_next = m_state;
    case (m_state)
      M_IDLE:  if (move_start) m_next = M_SETUP;
      M_SETUP: m_next = M_RUN;
      M_RUN:   if (pc_wrap && remaining == 31'd1) m_next = M_IDLE;
      default: m_next = M_IDLE;
    endcase
    if (abort) m_next = M_IDLE;
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      period_eng <= 32'd0;
      pc         <= 32'd0;
      remaining  <= 31'd0;
    end else begin
      case (m_state)
        M_SETUP: begin
          period_eng <= period;
          pc         <= 32'd0;
          remaining  <= move_n_q;
        end
        M_RUN: begin
          if (pc_wrap) begin
            pc        <= 32'd0;
            remaining <= remaining - 31'd1;
          end else begin
            pc <= pc + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy = (m_state != M_IDLE);
    step = (m_state == M_RUN) && (pc < (period_eng >> 1));
  end

  // ---------------------------------------------------------------- status byte
  always_ff @(posedge CLK) begin
    if (reset) spi_send_data <= {1'b0, 1'b0, 1'b0, 1'b1, 4'b0000};
    else       spi_send_data <= {busy, fault, enable, dir, 4'b0000};
  end

endmodule
